// File: rtl/multi_clk_generator_pkg.sv
// Shared definitions for the multi-channel derived clock / tick generator.
package multi_clk_generator_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } ch_state_e;

  localparam logic MODE_TOGGLE = 1'b0;
  localparam logic MODE_PULSE  = 1'b1;

endpackage

// File: rtl/multi_clk_generator_channel.sv
// One generator channel: IDLE/RUN/DONE FSM, wrap-safe deadline and event counter.
module clk_gen_channel
  import multi_clk_generator_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] count,
  input  logic             en,
  input  logic             mode,
  input  logic [WIDTH-1:0] limit,
  input  logic [CNT_W-1:0] n_target,
  output logic             clk_out,
  output logic             done
);

  localparam logic [WIDTH-1:0] LIM_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] LIM_MIN = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] EVT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  ch_state_e        state;
  logic [WIDTH-1:0] deadline;
  logic [WIDTH-1:0] lim_q;
  logic [WIDTH-1:0] eff_limit;
  logic [WIDTH-1:0] diff;
  logic [CNT_W-1:0] evt;
  logic [CNT_W-1:0] tgt_q;
  logic [CNT_W-1:0] evt_inc;
  logic [CNT_W-1:0] evt_nxt;
  logic             mode_q;
  logic             expiry;
  logic             last_evt;

  // Periods are capped below half the timestamp range so the sign of
  // (count - deadline) always tells "reached" from "not yet".
  always_comb begin
    eff_limit = limit;
    if (limit == '0)
      eff_limit = LIM_MIN;
    else if (limit[WIDTH-1])
      eff_limit = LIM_MAX;
  end

  assign diff     = count - deadline;
  assign expiry   = ~diff[WIDTH-1];
  assign evt_inc  = evt + EVT_ONE;
  assign evt_nxt  = (evt == '1) ? evt : evt_inc;
  assign last_evt = (tgt_q != '0) && (evt_inc == tgt_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      clk_out  <= 1'b0;
      done     <= 1'b0;
      deadline <= '0;
      lim_q    <= '0;
      evt      <= '0;
      tgt_q    <= '0;
      mode_q   <= MODE_TOGGLE;
    end else begin
      case (state)
        IDLE: begin
          clk_out <= 1'b0;
          done    <= 1'b0;
          if (en) begin
            lim_q    <= eff_limit;
            deadline <= count + eff_limit;
            evt      <= '0;
            mode_q   <= mode;
            tgt_q    <= n_target;
            state    <= RUN;
          end
        end
        RUN: begin
          if (!en) begin
            state   <= IDLE;
            clk_out <= 1'b0;
          end else if (expiry) begin
            // Advance from the old deadline, not from count, so no drift accumulates.
            deadline <= deadline + lim_q;
            evt      <= evt_nxt;
            clk_out  <= (mode_q == MODE_PULSE) ? 1'b1 : ~clk_out;
            if (last_evt) begin
              state <= DONE;
              done  <= 1'b1;
            end
          end else if (mode_q == MODE_PULSE) begin
            clk_out <= 1'b0;
          end
        end
        DONE: begin
          if (!en) begin
            state   <= IDLE;
            done    <= 1'b0;
            clk_out <= 1'b0;
          end else if (mode_q == MODE_PULSE) begin
            clk_out <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          clk_out <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/multi_clk_generator.sv
// NUM_CH independent derived-clock / tick channels timed off a shared timestamp.
module multi_clk_generator
  import multi_clk_generator_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 32,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [WIDTH-1:0]        count,
  input  logic [NUM_CH-1:0]       en,
  input  logic [NUM_CH-1:0]       mode,
  input  logic [NUM_CH*WIDTH-1:0] limit,
  input  logic [NUM_CH*CNT_W-1:0] n_target,
  output logic [NUM_CH-1:0]       clk_out,
  output logic [NUM_CH-1:0]       done
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clk_gen_channel #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .count    (count),
      .en       (en[i]),
      .mode     (mode[i]),
      .limit    (limit[i*WIDTH +: WIDTH]),
      .n_target (n_target[i*CNT_W +: CNT_W]),
      .clk_out  (clk_out[i]),
      .done     (done[i])
    );
  end

endmodule

// File: tb/tb_multi_clk_generator.sv
// Directed self-checking bench for multi_clk_generator.
module tb_multi_clk_generator;

  localparam int NUM_CH = 4;
  localparam int WIDTH  = 32;
  localparam int CNT_W  = 16;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [WIDTH-1:0]        count;
  logic [NUM_CH-1:0]       en;
  logic [NUM_CH-1:0]       mode;
  logic [NUM_CH*WIDTH-1:0] limit;
  logic [NUM_CH*CNT_W-1:0] n_target;
  logic [NUM_CH-1:0]       clk_out;
  logic [NUM_CH-1:0]       done;

  int n_cmp = 0;
  int n_err = 0;

  multi_clk_generator #(
    .NUM_CH (NUM_CH),
    .WIDTH  (WIDTH),
    .CNT_W  (CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .count    (count),
    .en       (en),
    .mode     (mode),
    .limit    (limit),
    .n_target (n_target),
    .clk_out  (clk_out),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst   = 1'b0;
    en    = '0;
    count = '0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic cfg(input int ch, input logic m, input logic [WIDTH-1:0] lim,
                     input logic [CNT_W-1:0] tgt);
    mode[ch]                    = m;
    limit[ch*WIDTH +: WIDTH]    = lim;
    n_target[ch*CNT_W +: CNT_W] = tgt;
  endtask

  initial begin
    logic [3:0] e;

    rst      = 1'b0;
    en       = '1;
    mode     = '0;
    limit    = '0;
    n_target = '0;
    count    = '0;

    // reset held with all channels enabled
    for (int i = 0; i < 4; i++) begin
      count = 32'(i * 7);
      tick();
      check("rst_clk", 32'(clk_out), 32'h0);
      check("rst_done", 32'(done), 32'h0);
    end

    // toggle ch0, limit 5: level = floor(c/5) mod 2, 20 edges by c=100
    do_reset();
    cfg(0, 1'b0, 32'd5, 16'd0);
    en[0] = 1'b1;
    tick();
    for (int c = 1; c <= 100; c++) begin
      count = 32'(c);
      tick();
      check("toggle5", 32'(clk_out[0]), 32'((c / 5) % 2));
    end

    // pulse ch1, limit 3, 4 events: pulses at c=3,6,9,12, done from 12
    do_reset();
    cfg(1, 1'b1, 32'd3, 16'd4);
    en[1] = 1'b1;
    tick();
    for (int c = 1; c <= 20; c++) begin
      count = 32'(c);
      tick();
      check("pulse3_clk", 32'(clk_out[1]), 32'((c % 3 == 0) && (c <= 12)));
      check("pulse3_done", 32'(done[1]), 32'(c >= 12));
    end
    en[1] = 1'b0;
    count = 32'd21;
    tick();
    check("pulse3_done_clr", 32'(done[1]), 32'h0);
    check("pulse3_clk_clr", 32'(clk_out[1]), 32'h0);

    // wrap: start FFFF_FFFC, limit 8 -> first expiry at count 4
    do_reset();
    cfg(0, 1'b0, 32'd8, 16'd0);
    count = 32'hFFFF_FFFC;
    en[0] = 1'b1;
    tick();
    for (int i = 1; i <= 10; i++) begin
      count = 32'hFFFF_FFFC + 32'(i);
      tick();
      check("wrap", 32'(clk_out[0]), 32'(i >= 8));
    end

    // limit 0 behaves as 1
    do_reset();
    cfg(0, 1'b0, 32'd0, 16'd0);
    en[0] = 1'b1;
    tick();
    for (int c = 1; c <= 8; c++) begin
      count = 32'(c);
      tick();
      check("lim0", 32'(clk_out[0]), 32'(c % 2));
    end

    // oversize limit clamps to 7FFF_FFFF
    do_reset();
    cfg(0, 1'b0, 32'h8000_0000, 16'd0);
    en[0] = 1'b1;
    tick();
    count = 32'h7FFF_FFFE;
    tick();
    check("clamp_before", 32'(clk_out[0]), 32'h0);
    count = 32'h7FFF_FFFF;
    tick();
    check("clamp_at", 32'(clk_out[0]), 32'h1);

    // jump +20 with limit 5 in pulse mode: 4 consecutive expiry cycles
    do_reset();
    cfg(2, 1'b1, 32'd5, 16'd0);
    en[2] = 1'b1;
    tick();
    count = 32'd20;
    for (int i = 1; i <= 6; i++) begin
      tick();
      check("jump", 32'(clk_out[2]), 32'(i <= 4));
    end

    // disable in the expiry cycle wins
    do_reset();
    cfg(0, 1'b0, 32'd5, 16'd0);
    en[0] = 1'b1;
    tick();
    for (int c = 1; c <= 4; c++) begin
      count = 32'(c);
      tick();
    end
    check("endrop_pre", 32'(clk_out[0]), 32'h0);
    count = 32'd5;
    en[0] = 1'b0;
    tick();
    check("endrop_at", 32'(clk_out[0]), 32'h0);
    count = 32'd6;
    tick();
    check("endrop_after", 32'(clk_out[0]), 32'h0);

    // all four channels concurrently; ch0 limit change ignored until re-enable
    do_reset();
    cfg(0, 1'b0, 32'd2, 16'd0);
    cfg(1, 1'b1, 32'd3, 16'd0);
    cfg(2, 1'b0, 32'd6, 16'd0);
    cfg(3, 1'b1, 32'd4, 16'd3);
    en = '1;
    tick();
    for (int c = 1; c <= 30; c++) begin
      if (c == 14) cfg(0, 1'b0, 32'd7, 16'd0);
      if (c == 21) en[0] = 1'b0;
      if (c == 22) en[0] = 1'b1;
      count = 32'(c);
      tick();
      e[0] = (c <= 20) ? 1'((c / 2) % 2) : (c >= 29);
      e[1] = (c % 3 == 0);
      e[2] = 1'((c / 6) % 2);
      e[3] = (c % 4 == 0) && (c <= 12);
      check("multi_clk", 32'(clk_out), 32'(e));
      check("multi_done", 32'(done), 32'((c >= 12) ? 4'b1000 : 4'b0000));
    end
    check("prerst_pulse", 32'(clk_out[1]), 32'h1);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_clk", 32'(clk_out), 32'h0);
    check("async_rst_done", 32'(done), 32'h0);
    tick();
    rst = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
